// File: rtl/reg_dump_serializer.sv
// Register-file dump serializer: snapshots NUM_REGS 32-bit registers on request
// and streams header, data bytes (MSB first) and an XOR checksum over valid/ready.
module reg_dump_serializer #(
    parameter int unsigned NUM_REGS    = 32,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [32*NUM_REGS-1:0]   registers_flat,
    input  logic                     dump_request,
    input  logic                     tx_ready,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    output logic                     busy,
    output logic                     dump_done
);

    localparam int unsigned      NUM_BYTES = 4 * NUM_REGS;
    localparam int unsigned      IDX_W     = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HEADER = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;
    localparam logic [1:0] S_CSUM   = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             csum_q, csum_d;
    logic [32*NUM_REGS-1:0] snap_q, snap_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   xfer;
    logic [IDX_W-1:0]       nxt_idx;
    logic [IDX_W-1:0]       byte_sel;
    logic [7:0]             next_byte;

    assign xfer = tx_valid_q & tx_ready;

    // Byte index i maps to register i/4, byte 3-(i%4) in little-endian bit order,
    // which gives most-significant byte first on the wire.
    always_comb begin
        nxt_idx   = (state_q == S_DATA) ? idx_q + IDX_W'(1) : '0;
        byte_sel  = {nxt_idx[IDX_W-1:2], ~nxt_idx[1:0]};
        next_byte = snap_q[{byte_sel, 3'b000} +: 8];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        snap_d     = snap_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dump_request) begin
                    snap_d     = registers_flat;
                    idx_d      = '0;
                    csum_d     = 8'h00;
                    state_d    = S_HEADER;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HEADER_BYTE;
                end
            end
            S_HEADER: begin
                if (xfer) begin
                    state_d   = S_DATA;
                    tx_data_d = next_byte;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    // The checksum byte must already include the byte leaving now.
                    csum_d = csum_q ^ tx_data_q;
                    if (idx_q == LAST_IDX) begin
                        state_d   = S_CSUM;
                        tx_data_d = csum_q ^ tx_data_q;
                    end else begin
                        idx_d     = nxt_idx;
                        tx_data_d = next_byte;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            csum_q     <= 8'h00;
            snap_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            snap_q     <= snap_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign dump_done = done_q;

endmodule

// File: tb/tb_reg_dump_serializer.sv
// Self-checking bench for reg_dump_serializer: randomized tx_ready backpressure,
// frames compared against a byte-list model built from the register values.
module tb_reg_dump_serializer;

    localparam int NR = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [32*NR-1:0]  registers_flat;
    logic              dump_request;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              busy;
    logic              dump_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_regs [NR];
    logic [7:0]  exp_q [$];

    always #5 clock = ~clock;

    reg_dump_serializer #(.NUM_REGS(NR), .HEADER_BYTE(8'hA5)) dut (
        .clock          (clock),
        .reset          (reset),
        .registers_flat (registers_flat),
        .dump_request   (dump_request),
        .tx_ready       (tx_ready),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .busy           (busy),
        .dump_done      (dump_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_regs();
        for (int k = 0; k < NR; k++) registers_flat[32*k +: 32] = model_regs[k];
    endtask

    // Expected frame: header, each register's four bytes MSB first, XOR of data bytes.
    task automatic build_expected();
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < NR; k++) begin
            for (int j = 0; j < 4; j++) begin
                b = 8'((model_regs[k] >> (8 * (3 - j))) & 32'hFF);
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
        exp_q.push_back(cs);
    endtask

    // Called at the negedge where the header should already be presented.
    task automatic recv_frame(input string tag, input int ready_pct, input bit hold_req,
                              input bit poke_hdr, input int stop_after);
        int         idx = 0;
        int         cyc = 0;
        int         limit;
        bit         pstall = 0;
        bit         poked = 0;
        logic [7:0] pd = 8'h00;
        limit = (stop_after > 0) ? stop_after : exp_q.size();
        while (idx < limit && cyc < 5000) begin
            chk({tag, " valid"}, tx_valid, 1);
            chk({tag, " busy"}, busy, 1);
            if (pstall) chk({tag, " stall_data"}, tx_data, pd);
            dump_request = hold_req;
            if (poke_hdr && idx == 1 && !poked) begin
                registers_flat[31:0] = 32'hFFFF_FFFF;
                dump_request = 1'b1;
                poked = 1;
            end
            tx_ready = ($urandom_range(99) < ready_pct);
            if (tx_valid && tx_ready) begin
                chk($sformatf("%s byte%0d", tag, idx), tx_data, exp_q[idx]);
                idx++;
            end
            pstall = tx_valid && !tx_ready;
            pd = tx_data;
            @(negedge clock);
            cyc++;
        end
        if (idx < limit) chk({tag, " timeout"}, idx, limit);
        if (stop_after > 0) begin
            tx_ready = 1'b0;
        end else begin
            if (ready_pct >= 100) chk({tag, " cycles"}, cyc, exp_q.size());
            chk({tag, " done_pulse"}, dump_done, 1);
            chk({tag, " busy_end"}, busy, 0);
            chk({tag, " valid_end"}, tx_valid, 0);
        end
    endtask

    task automatic start_dump();
        dump_request = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b0;
        dump_request = 1'b0;
        tx_ready = 1'b0;
        registers_flat = '0;

        // Reset holds everything quiet regardless of inputs.
        for (int c = 0; c < 4; c++) begin
            dump_request = c[0];
            tx_ready = ~c[0];
            @(negedge clock);
            chk("rst valid", tx_valid, 0);
            chk("rst busy", busy, 0);
            chk("rst done", dump_done, 0);
            chk("rst data", tx_data, 0);
        end
        dump_request = 1'b0;
        reset = 1'b1;
        @(negedge clock);

        // Single dump, one non-zero register, ready held high.
        for (int k = 0; k < NR; k++) model_regs[k] = 32'h0;
        model_regs[5] = 32'hDEAD_BEEF;
        apply_regs();
        build_expected();
        start_dump();
        recv_frame("single", 100, 0, 0, 0);
        @(negedge clock);
        chk("single done_once", dump_done, 0);

        // Backpressure with known register pattern.
        for (int k = 0; k < NR; k++) model_regs[k] = 32'h1000_0000 + 32'(k);
        apply_regs();
        build_expected();
        start_dump();
        recv_frame("bp", 50, 0, 0, 0);

        // Register change and second request after header are both ignored.
        for (int k = 0; k < NR; k++) model_regs[k] = $urandom;
        apply_regs();
        build_expected();
        start_dump();
        recv_frame("snap", 60, 0, 1, 0);
        dump_request = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("snap no_refire", tx_valid, 0);
            chk("snap idle_busy", busy, 0);
        end

        // Reset mid-frame while stalled; output must fall without a clock edge.
        for (int k = 0; k < NR; k++) model_regs[k] = $urandom;
        apply_regs();
        build_expected();
        start_dump();
        recv_frame("midrst", 100, 0, 0, 50);
        @(negedge clock);
        chk("midrst stalled", tx_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst async_valid", tx_valid, 0);
        chk("midrst async_busy", busy, 0);
        chk("midrst async_data", tx_data, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        for (int k = 0; k < NR; k++) model_regs[k] = $urandom;
        apply_regs();
        build_expected();
        start_dump();
        recv_frame("fresh", 70, 0, 0, 0);

        // Continuous request: each header follows dump_done by one cycle.
        for (int k = 0; k < NR; k++) model_regs[k] = $urandom;
        apply_regs();
        build_expected();
        start_dump();
        for (int f = 0; f < 3; f++) begin
            recv_frame($sformatf("cont%0d", f), 75, f < 2, 0, 0);
            if (f < 2) begin
                for (int k = 0; k < NR; k++) model_regs[k] = $urandom;
                apply_regs();
                build_expected();
                @(negedge clock);
                chk("cont hdr_valid", tx_valid, 1);
                chk("cont hdr_data", tx_data, 8'hA5);
            end
        end
        dump_request = 1'b0;
        @(negedge clock);
        chk("cont stop", tx_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
